// File: rtl/i2s_tdm_rx_if.sv
// i2s_tdm_rx_if: serial-audio input pins and parallel word outputs.
// master drives the serial side, slave is the receiver.
interface i2s_tdm_rx_if #(
    parameter int BITS_PRECISION = 24,
    parameter int CHANNELS       = 2
);
    localparam int CH_W = $clog2(CHANNELS);

    logic                      ws;
    logic                      sd;
    logic                      lj_mode;
    logic [BITS_PRECISION-1:0] data_in;
    logic [CH_W-1:0]           channel;
    logic                      left_rightn;
    logic                      data_en;
    logic                      frame_err;
    logic                      locked;

    modport master (
        output ws, sd, lj_mode,
        input  data_in, channel, left_rightn,
        input  data_en, frame_err, locked
    );

    modport slave (
        input  ws, sd, lj_mode,
        output data_in, channel, left_rightn,
        output data_en, frame_err, locked
    );
endinterface

// File: rtl/i2s_tdm_rx.sv
// i2s_tdm_rx: N-slot TDM / I2S serial audio receiver.
// Locks on falling ws and delivers one word per slot tagged with its index.
module i2s_tdm_rx #(
    parameter int BITS_PRECISION = 24,
    parameter int SLOT_BITS      = 32,
    parameter int CHANNELS       = 2
) (
    input  logic        sck,
    input  logic        rst,
    i2s_tdm_rx_if.slave bus
);
    localparam int CH_W = $clog2(CHANNELS);
    localparam int BW   = $clog2(SLOT_BITS);

    localparam logic [BW-1:0]   BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0]   BIT_LSB   = BW'(BITS_PRECISION - 1);
    localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(CHANNELS - 1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t state_q, state_d;

    logic                      ws_d;
    logic                      lj_q, lj_d;
    logic [BW-1:0]             bit_cnt, bit_nx, bi;
    logic [CH_W-1:0]           slot_cnt, slot_nx, si;
    logic [BITS_PRECISION-1:0] sh, sh_nx, data_q;
    logic [CH_W-1:0]           chan_q;
    logic                      lr_q, en_q, err_q, lock_q;
    logic                      fe, at_end, early, missing;
    logic                      hunt_edge, run_samp, samp, word;

    // at_end marks the cycle E+F where the next frame edge must land
    assign fe        = ws_d & ~bus.ws;
    assign at_end    = lj_q ? (bit_cnt == '0 && slot_cnt == '0)
                            : (bit_cnt == BIT_LAST && slot_cnt == SLOT_LAST);
    assign hunt_edge = (state_q == HUNT) && fe;
    assign early     = (state_q == RUN) && fe && !at_end;
    assign missing   = (state_q == RUN) && !fe && at_end;
    assign run_samp  = (state_q == RUN) && !early && !(missing && lj_q);

    always_ff @(posedge sck or negedge rst) begin
        if (!rst) state_q <= HUNT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (hunt_edge) state_d = RUN;
            RUN:     if (missing) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Resync in LJ samples the edge cycle itself; in I2S it is skipped
    always_comb begin
        lj_d = lj_q;
        samp = 1'b0;
        bi   = '0;
        si   = '0;
        unique case (1'b1)
            hunt_edge, early: begin
                lj_d = bus.lj_mode;
                samp = bus.lj_mode;
            end
            run_samp: begin
                samp = 1'b1;
                bi   = bit_cnt;
                si   = slot_cnt;
            end
            default: ;
        endcase

        bit_nx  = '0;
        slot_nx = '0;
        if (samp) begin
            bit_nx  = (bi == BIT_LAST) ? '0 : bi + 1'b1;
            slot_nx = (bi != BIT_LAST)  ? si
                    : (si == SLOT_LAST) ? '0 : si + 1'b1;
        end

        sh_nx = sh;
        if (samp && int'(bi) < BITS_PRECISION)
            sh_nx = BITS_PRECISION'({sh, bus.sd});
        word = samp && (bi == BIT_LSB);
    end

    always_ff @(posedge sck or negedge rst) begin
        if (!rst) begin
            ws_d     <= 1'b0;
            lj_q     <= 1'b0;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            sh       <= '0;
            data_q   <= '0;
            chan_q   <= '0;
            lr_q     <= 1'b0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            ws_d     <= bus.ws;
            lj_q     <= lj_d;
            bit_cnt  <= bit_nx;
            slot_cnt <= slot_nx;
            sh       <= sh_nx;
            en_q     <= word;
            err_q    <= early || missing;
            lock_q   <= (state_d == RUN);
            if (word) begin
                data_q <= sh_nx;
                chan_q <= si;
                lr_q   <= (si == '0);
            end
        end
    end

    assign bus.data_in     = data_q;
    assign bus.channel     = chan_q;
    assign bus.left_rightn = lr_q;
    assign bus.data_en     = en_q;
    assign bus.frame_err   = err_q;
    assign bus.locked      = lock_q;
endmodule

// File: tb/tb_i2s_tdm_rx.sv
// tb_i2s_tdm_rx: three receiver configurations driven from prebuilt
// serial streams, checked cycle by cycle against a frame-level model.
module tb_i2s_tdm_rx;
    localparam int MAXC = 1200;
    localparam int ASZ  = MAXC + 80;

    logic sck = 1'b0;
    logic rst = 1'b0;
    logic ws  = 1'b1;
    logic sd  = 1'b0;
    logic lj  = 1'b0;
    int   sel = 0;

    int errors = 0;
    int checks = 0;

    always #5 sck = ~sck;

    i2s_tdm_rx_if #(.BITS_PRECISION(24), .CHANNELS(2)) b0 ();
    i2s_tdm_rx_if #(.BITS_PRECISION(24), .CHANNELS(8)) b1 ();
    i2s_tdm_rx_if #(.BITS_PRECISION(16), .CHANNELS(2)) b2 ();

    assign b0.ws = ws;
    assign b0.sd = sd;
    assign b0.lj_mode = lj;
    assign b1.ws = ws;
    assign b1.sd = sd;
    assign b1.lj_mode = lj;
    assign b2.ws = ws;
    assign b2.sd = sd;
    assign b2.lj_mode = lj;

    i2s_tdm_rx #(
        .BITS_PRECISION(24), .SLOT_BITS(32), .CHANNELS(2)
    ) u0 (.sck(sck), .rst(rst), .bus(b0.slave));

    i2s_tdm_rx #(
        .BITS_PRECISION(24), .SLOT_BITS(32), .CHANNELS(8)
    ) u1 (.sck(sck), .rst(rst), .bus(b1.slave));

    i2s_tdm_rx #(
        .BITS_PRECISION(16), .SLOT_BITS(16), .CHANNELS(2)
    ) u2 (.sck(sck), .rst(rst), .bus(b2.slave));

    logic        o_en, o_err, o_lk, o_lr;
    logic [31:0] o_d, o_c;

    always_comb begin
        o_en  = b0.data_en;
        o_err = b0.frame_err;
        o_lk  = b0.locked;
        o_lr  = b0.left_rightn;
        o_d   = 32'(b0.data_in);
        o_c   = 32'(b0.channel);
        if (sel == 1) begin
            o_en  = b1.data_en;
            o_err = b1.frame_err;
            o_lk  = b1.locked;
            o_lr  = b1.left_rightn;
            o_d   = 32'(b1.data_in);
            o_c   = 32'(b1.channel);
        end else if (sel == 2) begin
            o_en  = b2.data_en;
            o_err = b2.frame_err;
            o_lk  = b2.locked;
            o_lr  = b2.left_rightn;
            o_d   = 32'(b2.data_in);
            o_c   = 32'(b2.channel);
        end
    end

    // stimulus stream
    logic        ws_a [ASZ];
    logic        sd_a [ASZ];
    logic        lj_a [ASZ];
    logic [31:0] fv   [8];

    // expected per-cycle outputs
    logic        m_en [ASZ];
    logic        m_err[ASZ];
    logic        m_lk [ASZ];
    logic [31:0] m_w  [ASZ];
    logic [31:0] m_c  [ASZ];
    logic [31:0] m_hd [ASZ];
    logic [31:0] m_hc [ASZ];
    logic        m_hl [ASZ];

    // observed log for directed checks
    logic        lg_en [ASZ];
    logic        lg_err[ASZ];
    logic        lg_lk [ASZ];
    logic [31:0] lg_d  [ASZ];
    logic [31:0] lg_c  [ASZ];

    task automatic ck(input string tag, input int t,
                      input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h",
                   tag, t, o, e);
        end
    endtask

    task automatic init_scn();
        for (int t = 0; t < ASZ; t++) begin
            ws_a[t] = 1'b1;
            sd_a[t] = 1'($urandom_range(0, 1));
            lj_a[t] = 1'($urandom_range(0, 1));
        end
    endtask

    // ws low for the first slot, slot k word from fv[k], MSB first
    task automatic put_frame(input int e, input int sb, input int bp,
                             input int ch, input logic ljm);
        int s0;
        for (int t = e; t < e + sb * ch; t++)
            ws_a[t] = (t >= e + sb);
        lj_a[e] = ljm;
        s0 = e + (ljm ? 0 : 1);
        for (int k = 0; k < ch; k++)
            for (int j = 0; j < sb; j++)
                sd_a[s0 + k * sb + j] = (j < bp) ? fv[k][bp - 1 - j]
                                      : 1'($urandom_range(0, 1));
    endtask

    task automatic rnd_fv(input int bp);
        for (int k = 0; k < 8; k++)
            fv[k] = $urandom & ((32'd1 << bp) - 1);
    endtask

    // frame-level reference: edges, expected next edge at E+F,
    // words collected from the sd stream at their sample cycles
    task automatic model(input int n, input int sb, input int bp,
                         input int ch);
        int          f, e, s0, d;
        logic        lk, fe, exp_edge, ljl;
        logic [31:0] w, cw, cc;
        logic        cl;
        f = sb * ch;
        e = 0;
        lk = 1'b0;
        ljl = 1'b0;
        for (int t = 0; t < ASZ; t++) begin
            m_en[t] = 1'b0;
            m_err[t] = 1'b0;
            m_lk[t] = 1'b0;
            m_w[t] = '0;
            m_c[t] = '0;
        end
        for (int t = 0; t < n; t++) begin
            fe = (t > 0) && ws_a[t - 1] && !ws_a[t];
            exp_edge = lk && (t == e + f);
            if (exp_edge && !fe) begin
                m_err[t + 1] = 1'b1;
                lk = 1'b0;
            end else if (fe) begin
                if (lk && !exp_edge) begin
                    m_err[t + 1] = 1'b1;
                    for (int u = t + 1; u <= n; u++) m_en[u] = 1'b0;
                end
                if (!exp_edge) ljl = lj_a[t];
                lk = 1'b1;
                e = t;
                s0 = t + (ljl ? 0 : 1);
                for (int k = 0; k < ch; k++) begin
                    d = s0 + k * sb + bp;
                    if (d <= n) begin
                        w = '0;
                        for (int j = 0; j < bp; j++)
                            w = (w << 1) | 32'(sd_a[s0 + k * sb + j]);
                        m_en[d] = 1'b1;
                        m_w[d] = w;
                        m_c[d] = k;
                    end
                end
            end
            m_lk[t + 1] = lk;
        end
        cw = '0;
        cc = '0;
        cl = 1'b0;
        for (int t = 0; t <= n; t++) begin
            if (m_en[t]) begin
                cw = m_w[t];
                cc = m_c[t];
                cl = (m_c[t] == 0);
            end
            m_hd[t] = cw;
            m_hc[t] = cc;
            m_hl[t] = cl;
        end
    endtask

    task automatic rst_checks(input string tag);
        ck({tag, "_data_in"}, -1, o_d, 32'd0);
        ck({tag, "_channel"}, -1, o_c, 32'd0);
        ck({tag, "_lr"}, -1, 32'(o_lr), 32'd0);
        ck({tag, "_data_en"}, -1, 32'(o_en), 32'd0);
        ck({tag, "_frame_err"}, -1, 32'(o_err), 32'd0);
        ck({tag, "_locked"}, -1, 32'(o_lk), 32'd0);
    endtask

    // entered at a negedge with rst low; leaves it released
    task automatic start_scn();
        ws = 1'b1;
        sd = 1'b0;
        repeat (2) @(negedge sck);
        rst_checks("rst");
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        for (int t = 0; t <= n; t++) begin
            lg_en[t] = o_en;
            lg_err[t] = o_err;
            lg_lk[t] = o_lk;
            lg_d[t] = o_d;
            lg_c[t] = o_c;
            ck("data_en", t, 32'(o_en), 32'(m_en[t]));
            ck("frame_err", t, 32'(o_err), 32'(m_err[t]));
            ck("locked", t, 32'(o_lk), 32'(m_lk[t]));
            ck("data_in", t, o_d, m_hd[t]);
            ck("channel", t, o_c, m_hc[t]);
            ck("left_rightn", t, 32'(o_lr), 32'(m_hl[t]));
            if (t < n) begin
                ws = ws_a[t];
                sd = sd_a[t];
                lj = lj_a[t];
                @(negedge sck);
            end
        end
    endtask

    task automatic next_scn(input int s);
        @(negedge sck);
        rst = 1'b0;
        sel = s;
        start_scn();
    endtask

    int cnt;

    initial begin
        // stereo I2S, 10 frames of fixed words then random ones
        sel = 0;
        @(negedge sck);
        start_scn();
        init_scn();
        for (int i = 0; i < 12; i++) begin
            rnd_fv(24);
            if (i < 10) begin
                fv[0] = 32'hABCDEF;
                fv[1] = 32'h123456;
            end
            put_frame(4 + 64 * i, 32, 24, 2, 1'b0);
        end
        model(812, 32, 24, 2);
        run(812);
        ck("lock_before", 4, 32'(lg_lk[4]), 32'd0);
        ck("lock_rise", 5, 32'(lg_lk[5]), 32'd1);
        ck("left_en", 29, 32'(lg_en[29]), 32'd1);
        ck("left_ch", 29, lg_c[29], 32'd0);
        ck("left_data", 29, lg_d[29], 32'hABCDEF);
        ck("right_en", 61, 32'(lg_en[61]), 32'd1);
        ck("right_ch", 61, lg_c[61], 32'd1);
        ck("right_data", 61, lg_d[61], 32'h123456);
        cnt = 0;
        for (int t = 0; t <= 4 + 640; t++) cnt += int'(lg_err[t]);
        ck("err_10fr", 644, cnt, 32'd0);
        cnt = 0;
        for (int t = 0; t <= 4 + 640; t++) cnt += int'(lg_en[t]);
        ck("strobes_10fr", 644, cnt, 32'd20);

        // 8-slot TDM, left-justified
        next_scn(1);
        init_scn();
        for (int k = 0; k < 8; k++) fv[k] = 32'h100000 + k;
        put_frame(2, 32, 24, 8, 1'b1);
        rnd_fv(24);
        put_frame(258, 32, 24, 8, 1'b1);
        rnd_fv(24);
        put_frame(514, 32, 24, 8, 1'b1);
        model(790, 32, 24, 8);
        run(790);
        cnt = 0;
        for (int t = 2; t < 258; t++) cnt += int'(lg_en[t]);
        ck("tdm_strobes", 258, cnt, 32'd8);
        ck("tdm_first", 26, lg_d[26], 32'h100000);
        ck("tdm_last", 250, lg_d[250], 32'h100007);
        ck("tdm_last_ch", 250, lg_c[250], 32'd7);

        // 16/16 I2S: last LSB lands on the following edge cycle
        next_scn(2);
        init_scn();
        rnd_fv(16);
        put_frame(3, 16, 16, 2, 1'b0);
        rnd_fv(16);
        put_frame(35, 16, 16, 2, 1'b0);
        model(87, 16, 16, 2);
        run(87);
        ck("edge_lsb_en", 36, 32'(lg_en[36]), 32'd1);
        ck("edge_lsb_ch", 36, lg_c[36], 32'd1);
        ck("edge_lsb_err", 36, 32'(lg_err[36]), 32'd0);
        ck("miss_lsb_en", 68, 32'(lg_en[68]), 32'd1);
        ck("miss_lsb_err", 68, 32'(lg_err[68]), 32'd1);

        // early edge 10 cycles into slot 1
        next_scn(0);
        init_scn();
        rnd_fv(24);
        put_frame(3, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(67, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(110, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(174, 32, 24, 2, 1'b0);
        model(268, 32, 24, 2);
        run(268);
        ck("early_err", 111, 32'(lg_err[111]), 32'd1);
        ck("early_slot0", 92, 32'(lg_en[92]), 32'd1);
        ck("early_no_slot1", 124, 32'(lg_en[124]), 32'd0);
        ck("early_next_en", 135, 32'(lg_en[135]), 32'd1);
        ck("early_next_ch", 135, lg_c[135], 32'd0);

        // ws held low past E+F, then relock
        next_scn(0);
        init_scn();
        rnd_fv(24);
        put_frame(3, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(67, 32, 24, 2, 1'b0);
        for (int t = 99; t <= 150; t++) ws_a[t] = 1'b0;
        rnd_fv(24);
        put_frame(160, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(224, 32, 24, 2, 1'b0);
        model(318, 32, 24, 2);
        run(318);
        ck("miss_err", 132, 32'(lg_err[132]), 32'd1);
        ck("miss_unlock", 132, 32'(lg_lk[132]), 32'd0);
        ck("relock", 161, 32'(lg_lk[161]), 32'd1);
        ck("relock_en", 185, 32'(lg_en[185]), 32'd1);
        ck("relock_ch", 185, lg_c[185], 32'd0);

        // asynchronous reset mid-slot, then a fresh lock
        next_scn(0);
        init_scn();
        fv[0] = 32'h5A5A5A;
        fv[1] = 32'hC3C3C3;
        put_frame(3, 32, 24, 2, 1'b0);
        put_frame(67, 32, 24, 2, 1'b0);
        put_frame(131, 32, 24, 2, 1'b0);
        model(200, 32, 24, 2);
        run(78);
        #2 rst = 1'b0;
        #1 rst_checks("async_rst");
        @(negedge sck);
        start_scn();
        init_scn();
        rnd_fv(24);
        put_frame(9, 32, 24, 2, 1'b0);
        rnd_fv(24);
        put_frame(73, 32, 24, 2, 1'b0);
        model(180, 32, 24, 2);
        run(180);
        cnt = 0;
        for (int t = 0; t < 34; t++) cnt += int'(lg_en[t]);
        ck("post_rst_quiet", 34, cnt, 32'd0);
        ck("post_rst_en", 34, 32'(lg_en[34]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
